// File: rtl/parking_pkg.sv
// Shared types and default constants for the car park gate controller.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        CLOSE = 2'd2
    } state_t;

    typedef enum logic {
        DIR_ENTRY = 1'b0,
        DIR_EXIT  = 1'b1
    } dir_t;

    localparam int DEF_CAPACITY     = 3;
    localparam int DEF_OPEN_CYCLES  = 8;
    localparam int DEF_CLOSE_CYCLES = 2;

    function automatic dir_t opposite_dir(input dir_t d);
        return (d == DIR_ENTRY) ? DIR_EXIT : DIR_ENTRY;
    endfunction

endpackage

// File: rtl/parking_gate_scheduler_if.sv
// Lane sensor inputs and gate/display outputs of the gate controller.
interface parking_gate_scheduler_if #(
    parameter int COUNT_W = 2
);
    import parking_pkg::*;

    // No valid/ready pairs here: requests and pass_sensor are levels sampled
    // every clock, grants and timeout are single-cycle registered pulses.
    logic               entry_req;
    logic               exit_req;
    logic               pass_sensor;
    logic               gate_open;
    logic               grant_entry;
    logic               grant_exit;
    logic [COUNT_W-1:0] occupancy;
    logic [COUNT_W-1:0] free_spaces;
    logic               full;
    logic               busy;
    logic               timeout;
    state_t             dbg_state;

    modport master (
        output entry_req, exit_req, pass_sensor,
        input  gate_open, grant_entry, grant_exit, occupancy, free_spaces,
        input  full, busy, timeout, dbg_state
    );

    modport slave (
        input  entry_req, exit_req, pass_sensor,
        output gate_open, grant_entry, grant_exit, occupancy, free_spaces,
        output full, busy, timeout, dbg_state
    );

endinterface

// File: rtl/parking_lane_arbiter.sv
// Lane eligibility plus round-robin tie break; last_dir is its only state.
module parking_lane_arbiter
    import parking_pkg::*;
#(
    parameter int CAPACITY = DEF_CAPACITY,
    parameter int COUNT_W  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_entry_req,
    input  logic               i_exit_req,
    input  logic [COUNT_W-1:0] i_occupancy,
    input  logic               i_take,
    output logic               o_grant_valid,
    output dir_t               o_grant_dir
);

    localparam logic [COUNT_W-1:0] CAP_C = COUNT_W'(CAPACITY);

    dir_t r_last_dir;
    logic w_entry_elig;
    logic w_exit_elig;

    assign w_entry_elig = i_entry_req && (i_occupancy < CAP_C);
    assign w_exit_elig  = i_exit_req && (i_occupancy != '0);

    always_comb begin
        o_grant_valid = w_entry_elig || w_exit_elig;
        o_grant_dir   = DIR_EXIT;
        if (w_entry_elig && w_exit_elig) begin
            o_grant_dir = opposite_dir(r_last_dir);
        end else if (w_entry_elig) begin
            o_grant_dir = DIR_ENTRY;
        end
    end

    // Reset to EXIT so the first tie after reset goes to the entry lane.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_dir <= DIR_EXIT;
        end else if (i_take && o_grant_valid) begin
            r_last_dir <= o_grant_dir;
        end
    end

endmodule

// File: rtl/parking_gate_scheduler.sv
// Shares one barrier between entry and exit lanes: open/wait/close sequencing
// with bounded timers and the authoritative occupancy and free-space counts.
module parking_gate_scheduler
    import parking_pkg::*;
#(
    parameter int CAPACITY     = DEF_CAPACITY,
    parameter int COUNT_W      = 2,
    parameter int OPEN_CYCLES  = DEF_OPEN_CYCLES,
    parameter int CLOSE_CYCLES = DEF_CLOSE_CYCLES
) (
    input logic                     clk,
    input logic                     reset,
    parking_gate_scheduler_if.slave bus
);

    localparam int MAX_T   = (OPEN_CYCLES > CLOSE_CYCLES) ? OPEN_CYCLES : CLOSE_CYCLES;
    localparam int TIMER_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam logic [TIMER_W-1:0] OPEN_LOAD  = TIMER_W'(OPEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] CLOSE_LOAD = TIMER_W'(CLOSE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] CAP_C      = COUNT_W'(CAPACITY);

    state_t             r_state;
    dir_t               r_dir;
    logic [TIMER_W-1:0] r_timer;
    logic [COUNT_W-1:0] r_occ;
    logic [COUNT_W-1:0] r_free;
    logic               r_full;
    logic               r_gate;
    logic               r_grant_entry;
    logic               r_grant_exit;
    logic               r_busy;
    logic               r_timeout;

    logic               w_take;
    logic               w_grant_valid;
    dir_t               w_grant_dir;
    logic [COUNT_W-1:0] w_occ_next;

    assign w_take = (r_state == IDLE);

    parking_lane_arbiter #(
        .CAPACITY (CAPACITY),
        .COUNT_W  (COUNT_W)
    ) u_arbiter (
        .clk           (clk),
        .reset         (reset),
        .i_entry_req   (bus.entry_req),
        .i_exit_req    (bus.exit_req),
        .i_occupancy   (r_occ),
        .i_take        (w_take),
        .o_grant_valid (w_grant_valid),
        .o_grant_dir   (w_grant_dir)
    );

    // Eligibility already excludes increment at CAPACITY and decrement at 0.
    assign w_occ_next = (r_dir == DIR_ENTRY) ? (r_occ + COUNT_W'(1))
                                             : (r_occ - COUNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_dir         <= DIR_EXIT;
            r_timer       <= '0;
            r_occ         <= '0;
            r_free        <= CAP_C;
            r_full        <= 1'b0;
            r_gate        <= 1'b0;
            r_grant_entry <= 1'b0;
            r_grant_exit  <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_grant_entry <= 1'b0;
            r_grant_exit  <= 1'b0;
            r_timeout     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_grant_entry <= (w_grant_dir == DIR_ENTRY);
                        r_grant_exit  <= (w_grant_dir == DIR_EXIT);
                        r_gate        <= 1'b1;
                        r_busy        <= 1'b1;
                        r_dir         <= w_grant_dir;
                        r_timer       <= OPEN_LOAD;
                        r_state       <= OPEN;
                    end
                end
                OPEN: begin
                    // A pass on the last open cycle still counts and suppresses timeout.
                    if (bus.pass_sensor) begin
                        r_occ   <= w_occ_next;
                        r_free  <= CAP_C - w_occ_next;
                        r_full  <= (w_occ_next == CAP_C);
                        r_gate  <= 1'b0;
                        r_timer <= CLOSE_LOAD;
                        r_state <= CLOSE;
                    end else if (r_timer == '0) begin
                        r_gate    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_timer   <= CLOSE_LOAD;
                        r_state   <= CLOSE;
                    end else begin
                        r_timer <= r_timer - TIMER_W'(1);
                    end
                end
                CLOSE: begin
                    if (r_timer == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_timer <= r_timer - TIMER_W'(1);
                    end
                end
                default: begin
                    r_gate  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gate_open   = r_gate;
    assign bus.grant_entry = r_grant_entry;
    assign bus.grant_exit  = r_grant_exit;
    assign bus.occupancy   = r_occ;
    assign bus.free_spaces = r_free;
    assign bus.full        = r_full;
    assign bus.busy        = r_busy;
    assign bus.timeout     = r_timeout;
    assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Directed bench for parking_gate_scheduler: CAPACITY=3, OPEN_CYCLES=8, CLOSE_CYCLES=2.
module tb_parking_gate_scheduler;
    import parking_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    parking_gate_scheduler_if #(.COUNT_W(2)) bus ();

    parking_gate_scheduler #(
        .CAPACITY     (3),
        .COUNT_W      (2),
        .OPEN_CYCLES  (8),
        .CLOSE_CYCLES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic chk_counts(input string tag, input int exp_occ);
        chk({tag, "_occ"},  32'(bus.occupancy),   32'(exp_occ));
        chk({tag, "_free"}, 32'(bus.free_spaces), 32'(3 - exp_occ));
        chk({tag, "_full"}, 32'(bus.full),        32'(exp_occ == 3));
    endtask

    // One complete transaction with an immediate pass; ends back in IDLE.
    task automatic transact(input string tag, input logic ent, input logic ex,
                            input logic exp_entry, input int exp_occ);
        bus.entry_req = ent;
        bus.exit_req  = ex;
        step(1);
        chk({tag, "_gent"}, 32'(bus.grant_entry), 32'(exp_entry));
        chk({tag, "_gexit"}, 32'(bus.grant_exit), 32'(!exp_entry));
        chk({tag, "_gate"}, 32'(bus.gate_open), 32'd1);
        bus.entry_req   = 1'b0;
        bus.exit_req    = 1'b0;
        bus.pass_sensor = 1'b1;
        step(1);
        bus.pass_sensor = 1'b0;
        chk_counts(tag, exp_occ);
        chk({tag, "_gate_cl"}, 32'(bus.gate_open), 32'd0);
        step(2);
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.entry_req   = 1'b0;
        bus.exit_req    = 1'b0;
        bus.pass_sensor = 1'b0;
        do_reset();

        // reset values
        chk_counts("rst", 0);
        chk("rst_gate", 32'(bus.gate_open), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);
        chk("rst_state", 32'(bus.dbg_state), 32'(IDLE));

        // first entry, pass 3 cycles after grant, then close guard
        bus.entry_req = 1'b1;
        step(1);
        chk("e1_grant", 32'(bus.grant_entry), 32'd1);
        chk("e1_gexit", 32'(bus.grant_exit), 32'd0);
        chk("e1_gate", 32'(bus.gate_open), 32'd1);
        chk("e1_busy", 32'(bus.busy), 32'd1);
        chk("e1_state", 32'(bus.dbg_state), 32'(OPEN));
        bus.entry_req = 1'b0;
        step(1);
        chk("e1_pulse", 32'(bus.grant_entry), 32'd0);
        chk("e1_gate2", 32'(bus.gate_open), 32'd1);
        step(1);
        bus.pass_sensor = 1'b1;
        step(1);
        bus.pass_sensor = 1'b0;
        chk_counts("e1", 1);
        chk("e1_gate_cl", 32'(bus.gate_open), 32'd0);
        chk("e1_busy_cl", 32'(bus.busy), 32'd1);
        chk("e1_to", 32'(bus.timeout), 32'd0);
        step(1);
        chk("e1_busy_c2", 32'(bus.busy), 32'd1);
        step(1);
        chk("e1_busy_end", 32'(bus.busy), 32'd0);
        chk("e1_state_end", 32'(bus.dbg_state), 32'(IDLE));

        // fill the lot
        transact("e2", 1'b1, 1'b0, 1'b1, 2);
        transact("e3", 1'b1, 1'b0, 1'b1, 3);

        // full: entry request refused
        bus.entry_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("full_gent", 32'(bus.grant_entry), 32'd0);
            chk("full_gate", 32'(bus.gate_open), 32'd0);
            chk("full_busy", 32'(bus.busy), 32'd0);
        end
        bus.entry_req = 1'b0;
        step(1);

        // exit leaves last_dir EXIT, then round-robin ties
        transact("x1", 1'b0, 1'b1, 1'b0, 2);
        transact("tie1", 1'b1, 1'b1, 1'b1, 3);
        transact("tie2", 1'b1, 1'b1, 1'b0, 2);

        // tie goes to entry, no pass: 8 open cycles then timeout
        bus.entry_req = 1'b1;
        bus.exit_req  = 1'b1;
        step(1);
        chk("to_gent", 32'(bus.grant_entry), 32'd1);
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("to_gate_hi", 32'(bus.gate_open), 32'd1);
            chk("to_pulse_lo", 32'(bus.timeout), 32'd0);
            step(1);
        end
        chk("to_gate_lo", 32'(bus.gate_open), 32'd0);
        chk("to_pulse", 32'(bus.timeout), 32'd1);
        chk_counts("to", 2);
        step(1);
        chk("to_pulse_end", 32'(bus.timeout), 32'd0);
        chk("to_busy_c", 32'(bus.busy), 32'd1);
        step(1);
        chk("to_busy_end", 32'(bus.busy), 32'd0);

        // last grant was entry, so the tie now goes to exit
        transact("tie3", 1'b1, 1'b1, 1'b0, 1);

        // pass on the final open cycle; pass held through close is ignored
        bus.entry_req = 1'b1;
        step(1);
        chk("late_gent", 32'(bus.grant_entry), 32'd1);
        bus.entry_req = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("late_gate_hi", 32'(bus.gate_open), 32'd1);
            step(1);
        end
        chk("late_gate_last", 32'(bus.gate_open), 32'd1);
        bus.pass_sensor = 1'b1;
        step(1);
        chk_counts("late", 2);
        chk("late_to", 32'(bus.timeout), 32'd0);
        chk("late_gate_lo", 32'(bus.gate_open), 32'd0);
        step(1);
        chk_counts("late_close", 2);
        chk("late_gate_c", 32'(bus.gate_open), 32'd0);
        step(1);
        bus.pass_sensor = 1'b0;
        chk_counts("late_idle", 2);
        chk("late_busy_end", 32'(bus.busy), 32'd0);

        // reset while OPEN with occupancy 2
        bus.entry_req = 1'b1;
        step(1);
        chk("mr_gate_pre", 32'(bus.gate_open), 32'd1);
        bus.entry_req = 1'b0;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk_counts("mr", 0);
        chk("mr_gate", 32'(bus.gate_open), 32'd0);
        chk("mr_busy", 32'(bus.busy), 32'd0);
        chk("mr_gent", 32'(bus.grant_entry), 32'd0);
        chk("mr_gexit", 32'(bus.grant_exit), 32'd0);
        chk("mr_to", 32'(bus.timeout), 32'd0);
        chk("mr_state", 32'(bus.dbg_state), 32'(IDLE));

        // empty lot: exit request refused
        bus.exit_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("empty_gexit", 32'(bus.grant_exit), 32'd0);
            chk("empty_gate", 32'(bus.gate_open), 32'd0);
            chk("empty_busy", 32'(bus.busy), 32'd0);
        end
        bus.exit_req = 1'b0;
        step(1);

        // normal operation after reset
        transact("post", 1'b1, 1'b0, 1'b1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
